// File: rtl/det_engine_scheduler_pkg.sv
// det_engine_scheduler_pkg: shared widths, operand size limits and FSM encodings for the determinant scheduler
package det_engine_scheduler_pkg;
    localparam int ELEM_W   = 8;
    localparam int MATRIX_W = 25 * ELEM_W;
    localparam int DET_W    = 8;
    localparam logic [2:0] SZ_MIN = 3'd2;
    localparam logic [2:0] SZ_MAX = 3'd5;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    function automatic logic size_ok(input logic [2:0] s);
        return s >= SZ_MIN && s <= SZ_MAX;
    endfunction
endpackage

// File: rtl/det_engine_scheduler_arb.sv
// det_rr_arb2: combinational two-way round-robin grant
// Ports: req0_i/req1_i requests, last_grant_i previous winner,
//        valid_o any request present, grant_o winning index (0 or 1)
module det_rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic grant_o
);
    assign valid_o = req0_i | req1_i;
    assign grant_o = (req0_i & req1_i) ? ~last_grant_i : req1_i;
endmodule

// File: rtl/det_engine_scheduler.sv
// det_engine_scheduler: shares one determinant engine between two requesters with round-robin arbitration
// Ports: req0/req1 + matrix0/1 + size0/1 requester side, ack0/ack1 + det_out + err result return,
//        busy operation in flight, eng_start/eng_matrix/eng_size/eng_done/eng_det level handshake to the engine
module det_engine_scheduler
    import det_engine_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                req1,
    input  logic [MATRIX_W-1:0] matrix0,
    input  logic [MATRIX_W-1:0] matrix1,
    input  logic [2:0]          size0,
    input  logic [2:0]          size1,
    output logic                ack0,
    output logic                ack1,
    output logic [DET_W-1:0]    det_out,
    output logic                err,
    output logic                busy,
    output logic                eng_start,
    output logic [MATRIX_W-1:0] eng_matrix,
    output logic [2:0]          eng_size,
    input  logic                eng_done,
    input  logic [DET_W-1:0]    eng_det
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d, win_q, win_d, err_q, err_d, start_q, start_d, done_q;
    logic [DET_W-1:0]    res_q, res_d;
    logic [MATRIX_W-1:0] mat_q, mat_d;
    logic [2:0]          size_q, size_d;
    logic                gnt_valid, gnt, done_rise, resp;
    logic [2:0]          sel_size;

    det_rr_arb2 u_arb (
        .req0_i(req0),
        .req1_i(req1),
        .last_grant_i(last_q),
        .valid_o(gnt_valid),
        .grant_o(gnt)
    );

    assign sel_size  = gnt ? size1 : size0;
    // done_q lags eng_done by one cycle so only the rising edge completes an operation
    assign done_rise = eng_done & ~done_q;
    assign resp      = state_q == ST_RESP;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        win_d   = win_q;
        err_d   = err_q;
        start_d = start_q;
        res_d   = res_q;
        mat_d   = mat_q;
        size_d  = size_q;
        case (state_q)
            ST_IDLE: if (gnt_valid) begin
                last_d  = gnt;
                win_d   = gnt;
                mat_d   = gnt ? matrix1 : matrix0;
                size_d  = sel_size;
                res_d   = '0;
                err_d   = ~size_ok(sel_size);
                state_d = size_ok(sel_size) ? ST_LAUNCH : ST_RESP;
            end
            ST_LAUNCH: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            // a done edge takes priority over a timeout hitting in the same cycle
            ST_WAIT: if (done_rise) begin
                res_d   = eng_det;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                res_d   = '0;
                err_d   = 1'b1;
                state_d = ST_RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_RESP: begin
                start_d = 1'b0;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = eng_done ? ST_DRAIN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            mat_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            win_q   <= win_d;
            err_q   <= err_d;
            start_q <= start_d;
            done_q  <= eng_done;
            res_q   <= res_d;
            mat_q   <= mat_d;
            size_q  <= size_d;
        end
    end

    assign ack0       = resp & ~win_q;
    assign ack1       = resp & win_q;
    assign det_out    = resp ? res_q : '0;
    assign err        = resp & err_q;
    assign busy       = state_q != ST_IDLE;
    assign eng_start  = start_q;
    assign eng_matrix = mat_q;
    assign eng_size   = size_q;
endmodule

// File: tb/tb_det_engine_scheduler.sv
// tb_det_engine_scheduler: directed bench with a behavioural engine and a round-robin/determinant reference model
module tb_det_engine_scheduler;
    logic         clk = 1'b0, rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [199:0] matrix0 = '0, matrix1 = '0;
    logic [2:0]   size0 = '0, size1 = '0;
    logic         ack0, ack1, err, busy, eng_start;
    logic [7:0]   det_out;
    logic [199:0] eng_matrix;
    logic [2:0]   eng_size;
    logic         eng_done = 1'b0;
    logic [7:0]   eng_det = '0;

    int  checks = 0, errors = 0, cyc = 0;
    int  eng_delay = 7, ecnt = 0;
    bit  eng_hang = 1'b0;
    bit  m_last = 1'b1, mw, mbad, drop1, start_prev = 1'b0;
    logic [2:0]   msz;
    logic [199:0] mmat;
    logic [7:0]   med;
    int  n_acks = 0, n_starts = 0, last_ack_cyc = -10, start_cyc = -10, last_who = -1;
    logic [7:0] last_det = '0;
    logic       last_err = 1'b0;
    int  ack_seq[$];
    logic [199:0] m2, m5, ma, mb;
    int  c0, base, s0;

    det_engine_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .matrix0(matrix0), .matrix1(matrix1),
        .size0(size0), .size1(size1),
        .ack0(ack0), .ack1(ack1),
        .det_out(det_out), .err(err), .busy(busy),
        .eng_start(eng_start), .eng_matrix(eng_matrix), .eng_size(eng_size),
        .eng_done(eng_done), .eng_det(eng_det)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Leibniz expansion over all permutations, mod 256
    function automatic logic [7:0] det_of(input logic [199:0] m, input int n);
        int sum, prod, t, inv;
        bit ok;
        int idx[5];
        sum = 0;
        for (int p = 0; p < 3125; p++) begin
            t = p;
            ok = 1'b1;
            for (int i = 0; i < 5; i++) begin
                idx[i] = t % 5;
                t = t / 5;
            end
            for (int i = 0; i < 5; i++) begin
                if (i >= n && idx[i] != 0) ok = 1'b0;
                if (i < n && idx[i] >= n) ok = 1'b0;
                for (int j = 0; j < i; j++) if (i < n && idx[j] == idx[i]) ok = 1'b0;
            end
            if (ok) begin
                inv = 0;
                prod = 1;
                for (int i = 0; i < n; i++) begin
                    prod = prod * int'(m[(i*5+idx[i])*8 +: 8]);
                    for (int j = 0; j < i; j++) if (idx[j] > idx[i]) inv++;
                end
                sum = (inv % 2 == 1) ? sum - prod : sum + prod;
            end
        end
        return sum[7:0];
    endfunction

    function automatic logic [199:0] put(input logic [199:0] m, input int r, input int c, input int v);
        logic [199:0] o;
        o = m;
        o[(r*5+c)*8 +: 8] = v[7:0];
        return o;
    endfunction

    always @(posedge clk) begin
        if (!eng_start) begin
            ecnt <= 0;
            eng_done <= 1'b0;
            eng_det <= '0;
        end else begin
            ecnt <= ecnt + 1;
            if (!eng_hang && ecnt + 1 == eng_delay) begin
                eng_done <= 1'b1;
                eng_det <= det_of(eng_matrix, int'(eng_size));
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            m_last = 1'b1;
        end else begin
            chk("dual_ack", 32'(ack0 & ack1), 32'd0);
            chk("busy_with_start", 32'(eng_start & ~busy), 32'd0);
            if (eng_start && !start_prev) begin
                n_starts++;
                start_cyc = cyc;
            end
            if (cyc == last_ack_cyc + 1) chk("start_after_resp", 32'(eng_start), 32'd0);
            if (ack0 || ack1) begin
                mw   = (req0 && req1) ? !m_last : req1;
                msz  = mw ? size1 : size0;
                mmat = mw ? matrix1 : matrix0;
                mbad = msz < 3'd2 || msz > 3'd5 || eng_hang;
                med  = mbad ? 8'd0 : det_of(mmat, int'(msz));
                chk("ack_who", 32'(ack1), 32'(mw));
                chk("det_out", 32'(det_out), 32'(med));
                chk("err", 32'(err), 32'(mbad));
                m_last = mw;
                n_acks++;
                ack_seq.push_back(int'(ack1));
                last_who = int'(ack1);
                last_det = det_out;
                last_err = err;
                last_ack_cyc = cyc;
            end else begin
                chk("det_idle", 32'(det_out), 32'd0);
                chk("err_idle", 32'(err), 32'd0);
            end
        end
        start_prev = eng_start;
    end

    always @(negedge clk) if (!rst && (ack0 || ack1)) begin
        drop1 = ack1;
        @(posedge clk);
        #1;
        if (drop1) req1 = 1'b0; else req0 = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int k;
        k = 0;
        while (n_acks < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("ack_arrived", 32'(n_acks >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < budget);
        chk("idle_reached", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic at_cycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m2 = put(put(put(put('0, 0, 0, 3), 0, 1, 1), 1, 0, 2), 1, 1, 4);
        m5 = put(put(put(put(put(put(put('0, 0, 0, 2), 1, 1, 3), 2, 2, 1), 3, 3, 1), 4, 4, 41), 0, 4, 7), 1, 2, 5);
        ma = put(put(put(put(put(put(put(put('0, 0, 0, 2), 0, 2, 1), 1, 0, 1), 1, 1, 3), 1, 2, 2), 2, 0, 1), 2, 1, 1), 2, 2, 2);
        mb = put(put(put(put(put(put(put('0, 0, 0, 1), 0, 1, 2), 0, 2, 3), 1, 1, 1), 1, 2, 4), 2, 0, 5), 2, 1, 6);
        chk("model_2x2", 32'(det_of(m2, 2)), 32'h0A);
        chk("model_5x5", 32'(det_of(m5, 5)), 32'hF6);
        chk("model_3x3", 32'(det_of(ma, 3)), 32'd6);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_outs", 32'({ack0, ack1, err, busy, eng_start, det_out, eng_size}), 32'd0);
        chk("rst_matrix", 32'(|eng_matrix), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        matrix0 = ma; size0 = 3'd3; matrix1 = mb; size1 = 3'd3;
        eng_delay = 4; base = n_acks;
        req0 = 1'b1; req1 = 1'b1;
        wait_acks(base + 2, 80);
        chk("rr_first", 32'(ack_seq[base]), 32'd0);
        chk("rr_second", 32'(ack_seq[base+1]), 32'd1);
        wait_idle(40);
        req0 = 1'b1; req1 = 1'b1;
        wait_acks(base + 4, 80);
        chk("rr_third", 32'(ack_seq[base+2]), 32'd0);
        chk("rr_fourth", 32'(ack_seq[base+3]), 32'd1);
        wait_idle(40);

        matrix0 = m2; size0 = 3'd2; eng_delay = 7; base = n_acks;
        req0 = 1'b1; c0 = cyc;
        wait_acks(base + 1, 40);
        chk("t1_start_lat", 32'(start_cyc), 32'(c0 + 2));
        chk("t1_ack_lat", 32'(last_ack_cyc), 32'(c0 + 10));
        chk("t1_det", 32'(last_det), 32'h0A);
        chk("t1_err", 32'(last_err), 32'd0);
        chk("t1_who", 32'(last_who), 32'd0);
        wait_idle(40);
        chk("t1_one_ack", 32'(n_acks), 32'(base + 1));

        s0 = n_starts; base = n_acks;
        matrix1 = mb; size1 = 3'd6;
        req1 = 1'b1; c0 = cyc;
        wait_acks(base + 1, 10);
        chk("bad_ack_lat", 32'(last_ack_cyc), 32'(c0 + 1));
        chk("bad_who", 32'(last_who), 32'd1);
        chk("bad_err", 32'(last_err), 32'd1);
        chk("bad_det", 32'(last_det), 32'd0);
        wait_idle(20);
        chk("bad_no_start", 32'(n_starts), 32'(s0));

        eng_hang = 1'b1; base = n_acks;
        matrix0 = ma; size0 = 3'd4;
        req0 = 1'b1; c0 = cyc;
        wait_acks(base + 1, 60);
        chk("to_start_lat", 32'(start_cyc), 32'(c0 + 2));
        chk("to_ack_lat", 32'(last_ack_cyc), 32'(c0 + 19));
        chk("to_err", 32'(last_err), 32'd1);
        chk("to_det", 32'(last_det), 32'd0);
        at_cycle(c0 + 20);
        chk("to_busy_drain", 32'(busy), 32'd1);
        at_cycle(c0 + 21);
        chk("to_busy_clear", 32'(busy), 32'd0);
        eng_hang = 1'b0;
        tick();

        eng_delay = 7; base = n_acks;
        matrix0 = ma; size0 = 3'd3;
        req0 = 1'b1; c0 = cyc;
        at_cycle(c0 + 3);
        tick();
        rst = 1'b1; req0 = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_outs", 32'({ack0, ack1, err, busy, eng_start, det_out, eng_size}), 32'd0);
        chk("rst_wait_matrix", 32'(|eng_matrix), 32'd0);
        repeat (12) @(negedge clk);
        chk("rst_no_ack", 32'(n_acks), 32'(base));
        tick();
        matrix0 = m2; size0 = 3'd2;
        req0 = 1'b1; c0 = cyc;
        wait_acks(base + 1, 40);
        chk("post_rst_lat", 32'(last_ack_cyc), 32'(c0 + 10));
        chk("post_rst_det", 32'(last_det), 32'h0A);
        chk("post_rst_who", 32'(last_who), 32'd0);
        wait_idle(40);

        eng_delay = 3; base = n_acks;
        matrix1 = m5; size1 = 3'd5;
        req1 = 1'b1; c0 = cyc;
        wait_acks(base + 1, 40);
        chk("neg_lat", 32'(last_ack_cyc), 32'(c0 + 6));
        chk("neg_det", 32'(last_det), 32'hF6);
        chk("neg_err", 32'(last_err), 32'd0);
        chk("neg_who", 32'(last_who), 32'd1);
        wait_idle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
